fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares one 8-bit byte FIFO write port among N_REQ packet producers.
//  Round-robin grant, held for a whole packet (until req_last), so packet bytes are never interleaved in the FIFO.
//  Sits directly upstream of the fifo write side; fifo_full is back-pressure.
//  Releases a stalled or over-length packet and flags an error.
// PARAMETERS
//  N_REQ     4    number of requesters (>=2)
//  MAX_PKT   256  max bytes per packet; grant is force-released after byte MAX_PKT
//  TIMEOUT   64   idle-valid cycles mid-packet before grant is revoked
// PORTS
//  clk          in   1          single clock, rising edge
//  reset_n      in   1          asynchronous, active-low reset
//  req_valid    in   N_REQ      requester i has a byte on req_data[i]
//  req_data     in   8*N_REQ    flat; byte i = req_data[8*i +: 8]
//  req_last     in   N_REQ      byte i is last of its packet
//  req_ready    out  N_REQ      byte i accepted this cycle when valid & ready
//  fifo_full    in   1          FIFO full flag
//  fifo_write   out  1          FIFO write strobe
//  fifo_data    out  8          FIFO write data
//  busy         out  1          a packet grant is held
//  grant_id     out  $clog2(N_REQ)  current/last granted requester
//  err_timeout  out  1          1-cycle pulse: grant revoked on stall
//  err_overlen  out  1          1-cycle pulse: grant revoked at MAX_PKT
//  err_id       out  $clog2(N_REQ)  requester of last error, held until next error
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, busy=0, grant_id=N_REQ-1 (so req 0 wins first), req_ready=0, fifo_write=0, fifo_data=0, err_*=0, counters=0.
//  Reset mid-packet aborts the packet silently. FIFO contents are untouched. The FIFO has its own reset.
//  FSM: IDLE, BURST.
//   IDLE: if any req_valid, pick first valid index after grant_id (wrapping modulo N_REQ). Register it into grant_id and go to BURST.
//         One cycle arbitration latency; no byte is accepted in IDLE.
//   BURST: beat = req_valid[g] & !fifo_full, where g = grant_id.
//     req_ready[g] = (state==BURST) & !fifo_full. All other req_ready bits are 0.
//     fifo_write = beat and fifo_data = req_data[g], both combinational from registered state; no write is issued while full.
//     beat & req_last[g] -> IDLE. Byte and stall counters clear.
//     beat & byte_cnt==MAX_PKT-1 & !last -> IDLE; pulse err_overlen, err_id=g.
//     !req_valid[g] & !fifo_full: stall_cnt++.
//        stall_cnt==TIMEOUT-1 -> IDLE; pulse err_timeout, err_id=g.
//     Any beat clears stall_cnt. fifo_full cycles neither count nor clear stall_cnt.
//  busy = (state==BURST).
//  After release, the next grant starts searching at g+1. The same requester is re-granted only if no other requester is valid.
//  Throughput: 1 byte/cycle within a packet; 1 idle cycle between packets.
//  Counters: byte_cnt has width $clog2(MAX_PKT+1); stall_cnt has width $clog2(TIMEOUT+1). Neither wraps: each is cleared on every exit from BURST.
//  Simultaneous last and MAX_PKT limit on the same beat: this is a normal end of packet, no err_overlen.
//  Requester-side rules: req_data and req_last are sampled only on a beat. Dropping req_valid mid-packet is legal until TIMEOUT.
// STRUCTURE
//  Package fifo_arb_pkg holds:
//   - typedef enum logic {IDLE, BURST} arb_state_t
//   - localparam BYTE_W = 8
//  Sub-module rr_pick #(N): combinational round-robin picker.
//   - Inputs: req vector, last index. Outputs: found, index.
//   - Implemented as a double-width priority encoder.
//  Top level holds the FSM, counters, data mux and error flags.
// TESTING
//  1. Reset, then req0 sends a 3-byte packet A1 A2 A3 -> grant on cycle 1; fifo_write high for 3 consecutive cycles with A1 A2 A3; busy drops after A3.
//  2. req0, req1 and req2 all valid with 2-byte packets -> FIFO order is r0,r0,r1,r1,r2,r2 with no interleaving; 1 idle cycle between packets.
//  3. fifo_full held high for 10 cycles mid-packet with TIMEOUT=4 -> no write, no err_timeout; packet resumes when full drops.
//  4. req1 granted, then drops valid for 64 cycles -> err_timeout pulses once, err_id=1, busy=0; req2 is granted next.
//  5. MAX_PKT=4, req3 sends 6 bytes without last -> 4 written, err_overlen pulses, err_id=3.
//     Bytes 5-6 start a new packet after re-arbitration.
//  6. reset_n asserted mid-packet -> all outputs reach reset values that cycle; the first grant after release goes to req0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {IDLE, BURST} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_i strictly after last_i, wrapping.
// Built as a priority encoder over the request vector concatenated with itself.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic            found_o,
  output logic [IdxW-1:0] idx_o
);

  logic [2*N-1:0] dbl_req;

  assign dbl_req = {req_i, req_i};

  // Scan high to low so the lowest qualifying position is the one that sticks.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = int'(2 * N) - 1; k >= 0; k--) begin
      if (dbl_req[k] && (k > int'(last_i))) begin
        found_o = 1'b1;
        idx_o   = IdxW'(k % int'(N));
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one byte-wide FIFO write port among N_REQ packet producers.
// Round-robin grant held for a whole packet; stalled or over-length packets are cut and flagged.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MAX_PKT = 256,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IdW    = $clog2(N_REQ),
  localparam int unsigned BcntW  = $clog2(MAX_PKT + 1),
  localparam int unsigned ScntW  = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [BYTE_W*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic                      fifo_full_i,
  output logic                      fifo_write_o,
  output logic [BYTE_W-1:0]         fifo_data_o,
  output logic                      busy_o,
  output logic [IdW-1:0]            grant_id_o,
  output logic                      err_timeout_o,
  output logic                      err_overlen_o,
  output logic [IdW-1:0]            err_id_o
);

  arb_state_t       state_q, state_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [BcntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [ScntW-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_overlen_q, err_overlen_d;
  logic [IdW-1:0]   err_id_q, err_id_d;

  logic              pick_found;
  logic [IdW-1:0]    pick_idx;
  logic              in_burst, g_valid, g_last;
  logic [BYTE_W-1:0] g_data;
  logic              beat, stall, last_beat, overlen, timeout, release_now;

  rr_pick #(
    .N(N_REQ)
  ) u_rr_pick (
    .req_i  (req_valid_i),
    .last_i (grant_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  always_comb begin
    g_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q == IdW'(i)) g_data = req_data_i[BYTE_W*i +: BYTE_W];
    end
  end

  always_comb begin
    in_burst    = (state_q == BURST);
    g_valid     = req_valid_i[grant_q];
    g_last      = req_last_i[grant_q];
    beat        = in_burst & g_valid & ~fifo_full_i;
    stall       = in_burst & ~g_valid & ~fifo_full_i;
    last_beat   = beat & g_last;
    // A last byte landing exactly on the limit is a normal end, not an overlength.
    overlen     = beat & ~g_last & (byte_cnt_q == BcntW'(MAX_PKT - 1));
    timeout     = stall & (stall_cnt_q == ScntW'(TIMEOUT - 1));
    release_now = last_beat | overlen | timeout;
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found) state_d = BURST;
      BURST:   if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d       = grant_q;
    byte_cnt_d    = byte_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    err_timeout_d = timeout;
    err_overlen_d = overlen;
    err_id_d      = (timeout | overlen) ? grant_q : err_id_q;
    if (!in_burst && pick_found) grant_d = pick_idx;
    if (release_now) begin
      byte_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (beat) begin
        byte_cnt_d  = byte_cnt_q + BcntW'(1);
        stall_cnt_d = '0;
      end else if (stall) begin
        stall_cnt_d = stall_cnt_q + ScntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      grant_q       <= IdW'(N_REQ - 1);
      byte_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
      err_overlen_q <= 1'b0;
      err_id_q      <= '0;
    end else begin
      grant_q       <= grant_d;
      byte_cnt_q    <= byte_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_overlen_q <= err_overlen_d;
      err_id_q      <= err_id_d;
    end
  end

  // Output logic
  always_comb begin
    req_ready_o = '0;
    if (in_burst && !fifo_full_i) req_ready_o[grant_q] = 1'b1;
    fifo_write_o  = beat;
    fifo_data_o   = in_burst ? g_data : '0;
    busy_o        = in_burst;
    grant_id_o    = grant_q;
    err_timeout_o = err_timeout_q;
    err_overlen_o = err_overlen_q;
    err_id_o      = err_id_q;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter: one default instance (a) and one with
// small MAX_PKT/TIMEOUT (b) share the stimulus; each step checks whichever instance it targets.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  valid, last;
  logic [31:0] data;
  logic        full;

  logic [3:0] a_ready, b_ready;
  logic       a_fw, b_fw, a_busy, b_busy, a_eto, b_eto, a_eol, b_eol;
  logic [7:0] a_fd, b_fd;
  logic [1:0] a_gid, b_gid, a_eid, b_eid;

  logic       sel_b;
  logic [3:0] o_ready;
  logic       o_fw, o_busy, o_eto, o_eol;
  logic [7:0] o_fd;
  logic [1:0] o_gid, o_eid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter u_dut_a (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .req_valid_i  (valid),
    .req_data_i   (data),
    .req_last_i   (last),
    .req_ready_o  (a_ready),
    .fifo_full_i  (full),
    .fifo_write_o (a_fw),
    .fifo_data_o  (a_fd),
    .busy_o       (a_busy),
    .grant_id_o   (a_gid),
    .err_timeout_o(a_eto),
    .err_overlen_o(a_eol),
    .err_id_o     (a_eid)
  );

  fifo_write_arbiter #(
    .N_REQ  (4),
    .MAX_PKT(4),
    .TIMEOUT(4)
  ) u_dut_b (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .req_valid_i  (valid),
    .req_data_i   (data),
    .req_last_i   (last),
    .req_ready_o  (b_ready),
    .fifo_full_i  (full),
    .fifo_write_o (b_fw),
    .fifo_data_o  (b_fd),
    .busy_o       (b_busy),
    .grant_id_o   (b_gid),
    .err_timeout_o(b_eto),
    .err_overlen_o(b_eol),
    .err_id_o     (b_eid)
  );

  assign o_ready = sel_b ? b_ready : a_ready;
  assign o_fw    = sel_b ? b_fw    : a_fw;
  assign o_fd    = sel_b ? b_fd    : a_fd;
  assign o_busy  = sel_b ? b_busy  : a_busy;
  assign o_gid   = sel_b ? b_gid   : a_gid;
  assign o_eto   = sel_b ? b_eto   : a_eto;
  assign o_eol   = sel_b ? b_eol   : a_eol;
  assign o_eid   = sel_b ? b_eid   : a_eid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input string tag, input logic [7:0] d, input int g);
    chk({tag, "_fw"}, 32'(o_fw), 32'd1);
    chk({tag, "_data"}, 32'(o_fd), 32'(d));
    chk({tag, "_gid"}, 32'(o_gid), 32'(g));
    chk({tag, "_ready"}, 32'(o_ready), 32'd1 << g);
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, "_fw"}, 32'(o_fw), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_ready"}, 32'(o_ready), 32'd0);
  endtask

  task automatic exp_reset_vals(input string tag);
    exp_idle(tag);
    chk({tag, "_gid"}, 32'(o_gid), 32'd3);
    chk({tag, "_fd"}, 32'(o_fd), 32'd0);
    chk({tag, "_eto"}, 32'(o_eto), 32'd0);
    chk({tag, "_eol"}, 32'(o_eol), 32'd0);
    chk({tag, "_eid"}, 32'(o_eid), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid = '0;
    last = '0;
    data = '0;
    full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    sel_b = 1'b0;
    reset_n = 1'b0;
    valid = '0;
    last = '0;
    data = '0;
    full = 1'b0;

    // Reset values
    @(negedge clk);
    #1;
    exp_reset_vals("rst");
    sel_b = 1'b1;
    exp_reset_vals("rst_b");
    sel_b = 1'b0;

    // 1: single 3-byte packet from req0
    do_reset();
    @(negedge clk); valid = 4'b0001; data[7:0] = 8'hA1; #1;
    exp_idle("t1_arb");
    chk("t1_arb_gid", 32'(o_gid), 32'd3);
    @(negedge clk); #1; exp_wr("t1_b1", 8'hA1, 0);
    @(negedge clk); data[7:0] = 8'hA2; #1; exp_wr("t1_b2", 8'hA2, 0);
    @(negedge clk); data[7:0] = 8'hA3; last[0] = 1'b1; #1; exp_wr("t1_b3", 8'hA3, 0);
    @(negedge clk); valid = '0; last = '0; #1; exp_idle("t1_end");

    // 2: three competing requesters, packets kept whole, round-robin order
    do_reset();
    @(negedge clk);
    valid = 4'b0111; data[7:0] = 8'h10; data[15:8] = 8'h20; data[23:16] = 8'h30; #1;
    exp_idle("t2_arb0");
    @(negedge clk); #1; exp_wr("t2_r0a", 8'h10, 0);
    @(negedge clk); data[7:0] = 8'h11; last[0] = 1'b1; #1; exp_wr("t2_r0b", 8'h11, 0);
    @(negedge clk); data[7:0] = 8'h12; #1; exp_idle("t2_gap0");
    @(negedge clk); #1; exp_wr("t2_r1a", 8'h20, 1);
    @(negedge clk); data[15:8] = 8'h21; last[1] = 1'b1; #1; exp_wr("t2_r1b", 8'h21, 1);
    @(negedge clk); valid[1] = 1'b0; last[1] = 1'b0; #1; exp_idle("t2_gap1");
    @(negedge clk); #1; exp_wr("t2_r2a", 8'h30, 2);
    @(negedge clk); data[23:16] = 8'h31; last[2] = 1'b1; #1; exp_wr("t2_r2b", 8'h31, 2);
    @(negedge clk); valid[2] = 1'b0; last[2] = 1'b0; #1; exp_idle("t2_gap2");
    @(negedge clk); #1; exp_wr("t2_r0c", 8'h12, 0);
    @(negedge clk); valid = '0; last = '0; #1; exp_idle("t2_end");

    // 3: fifo_full mid-packet on the TIMEOUT=4 instance neither counts nor times out
    sel_b = 1'b1;
    do_reset();
    @(negedge clk); valid = 4'b0001; data[7:0] = 8'h40; #1; exp_idle("t3_arb");
    @(negedge clk); #1; exp_wr("t3_b1", 8'h40, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); valid = '0; #1;
      chk("t3_stall_busy", 32'(o_busy), 32'd1);
      chk("t3_stall_fw", 32'(o_fw), 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); full = 1'b1; #1;
      chk("t3_full_fw", 32'(o_fw), 32'd0);
      chk("t3_full_ready", 32'(o_ready), 32'd0);
      chk("t3_full_busy", 32'(o_busy), 32'd1);
      chk("t3_full_eto", 32'(o_eto), 32'd0);
    end
    @(negedge clk); full = 1'b0; #1;
    chk("t3_stall3_busy", 32'(o_busy), 32'd1);
    chk("t3_stall3_eto", 32'(o_eto), 32'd0);
    @(negedge clk); valid = 4'b0001; data[7:0] = 8'h41; last[0] = 1'b1; #1;
    exp_wr("t3_b2", 8'h41, 0);
    chk("t3_b2_eto", 32'(o_eto), 32'd0);
    @(negedge clk); valid = '0; last = '0; #1;
    exp_idle("t3_end");
    chk("t3_end_eto", 32'(o_eto), 32'd0);

    // 4: req1 stalls for TIMEOUT=64 cycles, grant revoked, req2 next
    sel_b = 1'b0;
    do_reset();
    @(negedge clk); valid = 4'b0010; data[15:8] = 8'h50; #1; exp_idle("t4_arb");
    @(negedge clk); #1; exp_wr("t4_b1", 8'h50, 1);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); valid = 4'b0100; data[23:16] = 8'h60; last = 4'b0100; #1;
      chk("t4_stall_busy", 32'(o_busy), 32'd1);
      chk("t4_stall_eto", 32'(o_eto), 32'd0);
    end
    @(negedge clk); #1;
    exp_idle("t4_rel");
    chk("t4_rel_eto", 32'(o_eto), 32'd1);
    chk("t4_rel_eid", 32'(o_eid), 32'd1);
    @(negedge clk); #1;
    exp_wr("t4_r2", 8'h60, 2);
    chk("t4_r2_eto", 32'(o_eto), 32'd0);
    chk("t4_r2_eid", 32'(o_eid), 32'd1);
    @(negedge clk); valid = '0; last = '0; #1; exp_idle("t4_end");

    // 5: MAX_PKT=4, req3 overruns; then a packet whose last byte hits the limit exactly
    sel_b = 1'b1;
    do_reset();
    @(negedge clk); valid = 4'b1000; data[31:24] = 8'h70; #1; exp_idle("t5_arb");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); data[31:24] = 8'h70 + 8'(i); #1;
      exp_wr("t5_ov", 8'h70 + 8'(i), 3);
      chk("t5_ov_eol", 32'(o_eol), 32'd0);
    end
    @(negedge clk); data[31:24] = 8'h74; #1;
    exp_idle("t5_rel");
    chk("t5_rel_eol", 32'(o_eol), 32'd1);
    chk("t5_rel_eid", 32'(o_eid), 32'd3);
    @(negedge clk); #1;
    exp_wr("t5_b5", 8'h74, 3);
    chk("t5_b5_eol", 32'(o_eol), 32'd0);
    @(negedge clk); data[31:24] = 8'h75; last = 4'b1000; #1; exp_wr("t5_b6", 8'h75, 3);
    @(negedge clk); data[31:24] = 8'h80; last = '0; #1; exp_idle("t5_gap");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); data[31:24] = 8'h80 + 8'(i); last = (i == 3) ? 4'b1000 : 4'b0000; #1;
      exp_wr("t5_ex", 8'h80 + 8'(i), 3);
    end
    @(negedge clk); valid = '0; last = '0; #1;
    exp_idle("t5_end");
    chk("t5_end_eol", 32'(o_eol), 32'd0);

    // 6: asynchronous reset mid-packet, first grant afterwards goes to req0
    sel_b = 1'b0;
    do_reset();
    @(negedge clk); valid = 4'b0001; data[7:0] = 8'h90; #1; exp_idle("t6_arb");
    @(negedge clk); #1; exp_wr("t6_b1", 8'h90, 0);
    @(negedge clk); data[7:0] = 8'h91; #1; exp_wr("t6_b2", 8'h91, 0);
    reset_n = 1'b0;
    #1;
    exp_reset_vals("t6_rst");
    valid = 4'b0011; data[7:0] = 8'h92; data[15:8] = 8'h93;
    @(negedge clk); reset_n = 1'b1; #1; exp_idle("t6_arb2");
    @(negedge clk); #1; exp_wr("t6_first", 8'h92, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
